// File: rtl/calc_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the calc_arbiter slice: datapath widths, the opcode
// encodings understood by the downstream simple_calculator, the controller
// FSM state type and the opcode legality helper.
// -----------------------------------------------------------------------------
package calc_pkg;

  localparam int CALC_W = 8;   // operand width
  localparam int RES_W  = 16;  // result width

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b011;
  localparam logic [2:0] OP_POW2 = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic is_legal_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_POW2);
  endfunction

endpackage

// File: rtl/calc_arbiter_if.sv
// -----------------------------------------------------------------------------
// calc_arbiter_if
// Request/response bus between the requesters and calc_arbiter.
//   req_valid/req_ready : per-requester valid/ready handshake
//   req_x/req_y/req_op  : packed per-requester payload (requester i at slot i)
//   rsp_valid/rsp_ready : shared response handshake
//   rsp_id/rsp_data/rsp_err : response tag, result, illegal-opcode flag
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface calc_arbiter_if
  import calc_pkg::*;
#(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*CALC_W-1:0] req_x;
  logic [NUM_REQ*CALC_W-1:0] req_y;
  logic [NUM_REQ*3-1:0]      req_op;

  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [ID_W-1:0]           rsp_id;
  logic [RES_W-1:0]          rsp_data;
  logic                      rsp_err;

  modport master (
    output req_valid, req_x, req_y, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_x, req_y, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );

endinterface

// File: rtl/calc_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter. The search starts at the pointer (one past the last
// winner) and wraps; the pointer only moves when the accept strobe is high.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (pointer -> 0)
//   req        : request vector
//   accept     : current grant was taken this cycle
//   grant      : one-hot grant (all zero when no request)
//   grant_idx  : index of the granted requester
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               accept,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] idx;
  logic            found;
  int              sum;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    sum       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = int'(ptr) + i;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      idx = ID_W'(sum);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/calc_arbiter.sv
// -----------------------------------------------------------------------------
// calc_arbiter
// Time-shares one combinational simple_calculator among NUM_REQ requesters.
// A round-robin winner is accepted in IDLE, its operands are registered onto
// calc_x/calc_y/calc_op, the result is captured SETTLE_CYCLES edges later and
// returned on the shared response channel tagged with the requester index.
// Parameters:
//   NUM_REQ       : number of requesters (2..8)
//   SETTLE_CYCLES : edges from operand launch to result capture (1..15)
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   bus (slave)             : request/response bus, see calc_arbiter_if
//   calc_x, calc_y, calc_op : registered operands to the calculator
//   calc_out                : calculator result
//   busy                    : high whenever the FSM is not in IDLE
// Build option:
//   CALC_ARB_OPCHECK_EN : when defined, illegal opcodes bypass EXEC and are
//                         answered with rsp_err=1, rsp_data=0; otherwise
//                         rsp_err is tied 0 and every opcode is executed.
// -----------------------------------------------------------------------------
module calc_arbiter
  import calc_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  calc_arbiter_if.slave     bus,
  output logic [CALC_W-1:0] calc_x,
  output logic [CALC_W-1:0] calc_y,
  output logic [2:0]        calc_op,
  input  logic [RES_W-1:0]  calc_out,
  output logic              busy
);

  localparam int ID_W = $clog2(NUM_REQ);

  state_t              state, state_nxt;
  logic [3:0]          cnt;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_idx;
  logic                accept;
  logic                op_ok;
  logic [CALC_W-1:0]   win_x, win_y;
  logic [2:0]          win_op;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (bus.req_valid),
    .accept    (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign win_x  = bus.req_x[grant_idx*CALC_W +: CALC_W];
  assign win_y  = bus.req_y[grant_idx*CALC_W +: CALC_W];
  assign win_op = bus.req_op[grant_idx*3 +: 3];

`ifdef CALC_ARB_OPCHECK_EN
  logic rsp_err_q;

  assign op_ok = is_legal_op(win_op);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_err_q <= 1'b0;
    end else if (accept) begin
      rsp_err_q <= !op_ok;
    end
  end

  assign bus.rsp_err = rsp_err_q;
`else
  assign op_ok       = 1'b1;
  assign bus.rsp_err = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = op_ok ? EXEC : RESP;
      EXEC:    if (cnt == '0) state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic; grants are only offered in IDLE and never while in reset
  always_comb begin
    accept        = 1'b0;
    bus.req_ready = '0;
    bus.rsp_valid = 1'b0;
    busy          = 1'b1;
    unique case (state)
      IDLE: begin
        busy          = 1'b0;
        accept        = rst_n && (|grant);
        bus.req_ready = rst_n ? grant : '0;
      end
      EXEC: ;
      RESP: bus.rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Operand launch, settle counter and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      calc_x       <= '0;
      calc_y       <= '0;
      calc_op      <= '0;
      bus.rsp_id   <= '0;
      bus.rsp_data <= '0;
    end else if (accept) begin
      bus.rsp_id <= grant_idx;
      cnt        <= 4'(SETTLE_CYCLES - 1);
      if (op_ok) begin
        calc_x  <= win_x;
        calc_y  <= win_y;
        calc_op <= win_op;
      end else begin
        // illegal opcode: calculator untouched, answer with zero data
        bus.rsp_data <= '0;
      end
    end else if (state == EXEC) begin
      if (cnt == '0) begin
        bus.rsp_data <= calc_out;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_calc_arbiter.sv
// -----------------------------------------------------------------------------
// tb_calc_arbiter
// Directed bench for calc_arbiter (NUM_REQ=4, SETTLE_CYCLES=2) with a
// behavioural simple_calculator attached to the calc_* ports.
// Calculator ops: 000 x+y, 001 x-y, 011 x*y, 100 1<<y, others {x,y}.
// -----------------------------------------------------------------------------
module tb_calc_arbiter;
  import calc_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int SETTLE  = 2;

  logic              clk;
  logic              rst_n;
  logic [CALC_W-1:0] calc_x, calc_y;
  logic [2:0]        calc_op;
  logic [RES_W-1:0]  calc_out;
  logic              busy;

  int n_chk  = 0;
  int n_pass = 0;

  int got_id[8];
  int got_data[8];
  int acc_t[8];
  int n_got;
  int n_acc;

  calc_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  calc_arbiter #(
    .NUM_REQ       (NUM_REQ),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .calc_x   (calc_x),
    .calc_y   (calc_y),
    .calc_op  (calc_op),
    .calc_out (calc_out),
    .busy     (busy)
  );

  always_comb begin
    calc_out = {calc_x, calc_y};
    case (calc_op)
      3'b000:  calc_out = 16'(calc_x) + 16'(calc_y);
      3'b001:  calc_out = 16'(calc_x) - 16'(calc_y);
      3'b011:  calc_out = 16'(calc_x) * 16'(calc_y);
      3'b100:  calc_out = 16'd1 << calc_y;
      default: calc_out = {calc_x, calc_y};
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic set_req(input int i, input logic [7:0] x, input logic [7:0] y,
                         input logic [2:0] op);
    bus.req_x[i*8 +: 8]  = x;
    bus.req_y[i*8 +: 8]  = y;
    bus.req_op[i*3 +: 3] = op;
    bus.req_valid[i]     = 1'b1;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Runs until n_exp responses were handed over, dropping each requester's
  // valid after its grant edge; records grant cycles and responses.
  task automatic drain(input int n_exp);
    logic [NUM_REQ-1:0] g;
    int cyc;
    n_got = 0;
    n_acc = 0;
    cyc   = 0;
    while (n_got < n_exp && cyc < 200) begin
      @(negedge clk);
      g = bus.req_ready;
      if (g != '0 && n_acc < 8) begin
        acc_t[n_acc] = cyc;
        n_acc++;
      end
      if (bus.rsp_valid && bus.rsp_ready && n_got < 8) begin
        got_id[n_got]   = int'(bus.rsp_id);
        got_data[n_got] = int'(bus.rsp_data);
        n_got++;
      end
      @(posedge clk);
      #1;
      bus.req_valid = bus.req_valid & ~g;
      cyc++;
    end
    chk("drain_count", 32'(n_got), 32'(n_exp));
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = '1;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.req_op    = '0;
    bus.rsp_ready = 1'b1;

    // reset state, requests pending but nothing granted
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_busy",      32'(busy), 0);
    chk("rst_calc",      32'({calc_x, calc_y, calc_op}), 0);
    chk("rst_rsp",       32'({bus.rsp_id, bus.rsp_data, bus.rsp_err}), 0);

    // single request from requester 2: 3+4
    do_reset();
    set_req(2, 8'd3, 8'd4, 3'b000);
    @(negedge clk);
    chk("t1_grant", 32'(bus.req_ready), 4);
    chk("t1_idle_busy", 32'(busy), 0);
    @(posedge clk);
    #1;
    bus.req_valid[2] = 1'b0;
    @(negedge clk);
    chk("t1_ready_drop", 32'(bus.req_ready), 0);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_calc_x", 32'(calc_x), 3);
    chk("t1_calc_y", 32'(calc_y), 4);
    chk("t1_vld_e0", 32'(bus.rsp_valid), 0);
    @(negedge clk);
    chk("t1_vld_e1", 32'(bus.rsp_valid), 0);
    @(negedge clk);
    chk("t1_vld_e2", 32'(bus.rsp_valid), 1);
    chk("t1_id", 32'(bus.rsp_id), 2);
    chk("t1_data", 32'(bus.rsp_data), 7);
    chk("t1_err", 32'(bus.rsp_err), 0);
    @(negedge clk);
    chk("t1_done_vld", 32'(bus.rsp_valid), 0);
    chk("t1_done_busy", 32'(busy), 0);

    // four concurrent requesters, round robin from 0
    do_reset();
    set_req(0, 8'd2, 8'd3, 3'b011);
    set_req(1, 8'd8, 8'd1, 3'b001);
    set_req(2, 8'd0, 8'd5, 3'b100);
    set_req(3, 8'd1, 8'd1, 3'b000);
    drain(4);
    chk("t2_id0", 32'(got_id[0]), 0);
    chk("t2_id1", 32'(got_id[1]), 1);
    chk("t2_id2", 32'(got_id[2]), 2);
    chk("t2_id3", 32'(got_id[3]), 3);
    chk("t2_d0", 32'(got_data[0]), 6);
    chk("t2_d1", 32'(got_data[1]), 7);
    chk("t2_d2", 32'(got_data[2]), 32);
    chk("t2_d3", 32'(got_data[3]), 2);
    chk("t2_gap01", 32'(acc_t[1] - acc_t[0]), SETTLE + 2);
    chk("t2_gap23", 32'(acc_t[3] - acc_t[2]), SETTLE + 2);

    // backpressure: 10+20 held in RESP while requester 0 waits
    do_reset();
    bus.rsp_ready = 1'b0;
    set_req(1, 8'd10, 8'd20, 3'b000);
    @(negedge clk);
    chk("t3_grant", 32'(bus.req_ready), 2);
    @(posedge clk);
    #1;
    bus.req_valid[1] = 1'b0;
    set_req(0, 8'd1, 8'd2, 3'b000);
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t3_stall_vld",   32'(bus.rsp_valid), 1);
      chk("t3_stall_id",    32'(bus.rsp_id), 1);
      chk("t3_stall_data",  32'(bus.rsp_data), 30);
      chk("t3_stall_ready", 32'(bus.req_ready), 0);
    end
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("t3_release_vld", 32'(bus.rsp_valid), 1);
    chk("t3_release_rdy", 32'(bus.req_ready), 0);
    @(posedge clk);
    #1;
    chk("t3_idle_vld", 32'(bus.rsp_valid), 0);
    chk("t3_idle_grant", 32'(bus.req_ready), 1);
    @(posedge clk);
    #1;
    bus.req_valid[0] = 1'b0;
    drain(1);
    chk("t3_next_id", 32'(got_id[0]), 0);
    chk("t3_next_data", 32'(got_data[0]), 3);

    // reset pulse during EXEC
    do_reset();
    set_req(3, 8'd7, 8'd7, 3'b011);
    @(negedge clk);
    chk("t4_grant", 32'(bus.req_ready), 8);
    @(posedge clk);
    #1;
    bus.req_valid[3] = 1'b0;
    @(negedge clk);
    chk("t4_exec_busy", 32'(busy), 1);
    rst_n = 1'b0;
    set_req(0, 8'd9, 8'd1, 3'b001);
    set_req(3, 8'd7, 8'd7, 3'b011);
    #1;
    chk("t4_rst_ready", 32'(bus.req_ready), 0);
    chk("t4_rst_vld",   32'(bus.rsp_valid), 0);
    chk("t4_rst_busy",  32'(busy), 0);
    chk("t4_rst_calc",  32'({calc_x, calc_y, calc_op}), 0);
    chk("t4_rst_rsp",   32'({bus.rsp_id, bus.rsp_data, bus.rsp_err}), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("t4_post_grant", 32'(bus.req_ready), 1);
    chk("t4_post_vld", 32'(bus.rsp_valid), 0);
    drain(2);
    chk("t4_id0", 32'(got_id[0]), 0);
    chk("t4_d0", 32'(got_data[0]), 8);
    chk("t4_id1", 32'(got_id[1]), 3);
    chk("t4_d1", 32'(got_data[1]), 49);

    // opcode 111 from requester 1 (calc regs hold 7,7,011 from before)
    set_req(1, 8'd5, 8'd6, 3'b111);
    @(negedge clk);
    chk("t5_grant", 32'(bus.req_ready), 2);
    @(posedge clk);
    #1;
    bus.req_valid[1] = 1'b0;
    @(negedge clk);
`ifdef CALC_ARB_OPCHECK_EN
    chk("t5_vld", 32'(bus.rsp_valid), 1);
    chk("t5_err", 32'(bus.rsp_err), 1);
    chk("t5_data", 32'(bus.rsp_data), 0);
    chk("t5_id", 32'(bus.rsp_id), 1);
    chk("t5_calc_op", 32'(calc_op), 3);
    chk("t5_calc_x", 32'(calc_x), 7);
`else
    chk("t5_vld_e0", 32'(bus.rsp_valid), 0);
    chk("t5_calc_op", 32'(calc_op), 7);
    @(negedge clk);
    chk("t5_vld_e1", 32'(bus.rsp_valid), 0);
    @(negedge clk);
    chk("t5_vld", 32'(bus.rsp_valid), 1);
    chk("t5_err", 32'(bus.rsp_err), 0);
    chk("t5_data", 32'(bus.rsp_data), 32'h0506);
    chk("t5_id", 32'(bus.rsp_id), 1);
`endif
    @(negedge clk);
    chk("t5_done", 32'(bus.rsp_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/calc_arbiter.md
# calc_arbiter

Time-shared controller for one `simple_calculator` datapath, which is combinational: 8-bit x/y, 3-bit operation, 16-bit out. Accepts operation requests from `NUM_REQ` independent requesters over valid/ready handshakes and grants them round-robin. It drives the calculator operands from registers, waits a fixed settle time, then captures the result. Each result is returned on a single shared response channel tagged with the requester index. The block sits between the calculator and the requesting control logic.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `SETTLE_CYCLES`, 2: clock edges between operand launch and result capture, 1..15.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req_valid` in `NUM_REQ`: request pending, one bit per requester.
- `req_ready` out `NUM_REQ`: request accepted this cycle, at most one bit set.
- `req_x` in `NUM_REQ`×8: operand x per requester, packed.
- `req_y` in `NUM_REQ`×8: operand y per requester, packed.
- `req_op` in `NUM_REQ`×3: opcode per requester, packed.
- `calc_x` out 8: registered operand x to the calculator.
- `calc_y` out 8: registered operand y to the calculator.
- `calc_op` out 3: registered opcode to the calculator.
- `calc_out` in 16: calculator result.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: downstream accepts the response.
- `rsp_id` out $clog2(`NUM_REQ`): index of the requester that owns the response.
- `rsp_data` out 16: captured result.
- `rsp_err` out 1: illegal opcode. Only driven when the opcode check is compiled in; otherwise tied 0.
- `busy` out 1: high in any state except IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - The arbiter selects the winner among the set bits of `req_valid`. `req_ready[winner]` is asserted combinationally.
  - On the accept edge:
    - latch the winner's x/y/op into `calc_x`/`calc_y`/`calc_op`;
    - latch the winner into `rsp_id`;
    - load settle counter = `SETTLE_CYCLES`-1;
    - go to EXEC.
  - No `req_valid` bit set: remain in IDLE, all `req_ready` bits 0.
- **EXEC**
  - Decrement the counter on each edge.
  - On the edge where the counter is 0: capture `calc_out` into `rsp_data`, then go to RESP.
  - The calc_* registers hold steady throughout EXEC.
- **RESP**
  - `rsp_valid`=1, and all response fields are stable until the handshake.
  - On `rsp_valid`&`rsp_ready`, go to IDLE.
  - No new grant is made in the same cycle, so IDLE lasts at least one cycle between operations.
- **Round-robin arbitration**
  - The priority pointer is the index after the last winner, with wrap-around (`NUM_REQ`-1 → 0).
  - After reset, the pointer is 0, so requester 0 has highest priority.
  - The pointer updates only on an accept.
- Requesters whose `req_valid` stays high while not granted keep waiting. Their payload must stay stable until they are granted.
- The opcode is not interpreted (except by the optional check below). `rsp_data` is the calculator's full 16-bit output.

## Timing
- Reset values: state IDLE, pointer 0, counter 0.
- Reset values of all outputs are 0: `calc_x`/`calc_y`/`calc_op`, `rsp_valid`, `rsp_id`, `rsp_data`, `rsp_err`, `busy`, and `req_ready`, which is forced 0 while `rst_n` is low.
- Accept edge to `rsp_valid` high: `SETTLE_CYCLES` edges.
- Minimum accept-to-accept interval: `SETTLE_CYCLES`+2 cycles, with `rsp_ready` held high.
- When `rsp_ready` is low, the block stalls in RESP indefinitely. No request is accepted while stalled.
- When `rst_n` is asserted mid-operation, the in-flight operation is discarded, no response is produced, and the pointer returns to 0.
- When `req_valid` changes in the same cycle as the return to IDLE, arbitration uses the value present in the IDLE cycle.

## Configuration
- Macro: `CALC_ARB_OPCHECK_EN`.
- Defined:
  - Legal opcodes are 000 add, 001 sub, 011 mul and 100 pow2.
  - An accepted illegal opcode skips EXEC and goes directly to RESP on the next edge, with `rsp_err`=1 and `rsp_data`=0.
  - The calc_* registers are not updated for an illegal opcode.
- Undefined: `rsp_err` is tied 0, and every opcode is run through EXEC unchanged.

## Structure
- Package `calc_pkg` contains:
  - the opcode constants `OP_ADD`, `OP_SUB`, `OP_MUL`, `OP_POW2`;
  - the function `is_legal_op`;
  - the FSM state enum;
  - the width constants `CALC_W`=8 and `RES_W`=16.
- Sub-module `rr_arbiter` provides request vector in, one-hot grant out, and a pointer update on an accept strobe.
- The `simple_calculator` instance lives outside the block and is connected at the level above.

## Test plan
- Single request: requester 2 sends x=3, y=4, op=000, `SETTLE_CYCLES`=2. Required: `req_ready[2]` for one cycle, then `rsp_valid` 2 edges later with `rsp_id`=2 and `rsp_data`=7.
- All four requesters hold `req_valid` with ops 011 (x=2,y=3), 001 (x=8,y=1), 100 (y=5), 000 (x=1,y=1). Required: responses in order id 0,1,2,3 with data 6, 7, 32, 2.
- Backpressure: hold `rsp_ready` low for 10 cycles during RESP. Required: response fields constant, no `req_ready` asserted, and the response is released on the first cycle `rsp_ready` is high.
- Reset pulse during EXEC. Required: all outputs 0, no response produced, and after release requester 0 wins over 3.
- With `CALC_ARB_OPCHECK_EN`: op=111. Required: `rsp_valid` one edge after accept, `rsp_err`=1, `rsp_data`=0, `calc_op` unchanged. Without the macro: the same stimulus gives `rsp_err`=0 after `SETTLE_CYCLES` edges.
